// File: rtl/fifo_burst_scheduler.sv
// rtl/fifo_burst_scheduler.sv - threshold/age gated burst scheduler draining per-channel FIFOs onto one stream
// Optional build macro: FIFO_SCHED_STRICT_EN selects strict lowest-index priority instead of round-robin.
module fifo_burst_scheduler #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int ABITS    = 4,
  parameter int BURST    = 8,
  parameter int THRESH   = 4,
  parameter int TIMEOUT  = 64,
  parameter int CBITS    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      enable_i,
  input  logic [CHANNELS*ABITS-1:0] level_i,
  input  logic [CHANNELS-1:0]       valid_i,
  output logic [CHANNELS-1:0]       ready_o,
  input  logic [CHANNELS*WIDTH-1:0] data_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic                      last_o,
  output logic [WIDTH-1:0]          data_o,
  output logic [CBITS-1:0]          chan_o,
  output logic                      busy_o
);

  localparam int RBITS = $clog2(BURST + 1);
  localparam int TBITS = $clog2(TIMEOUT + 1);
  localparam int LBITS = ABITS + 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CBITS-1:0] chan_q, chan_d;
  logic [CBITS-1:0] rr_q, rr_d;
  logic [RBITS-1:0] rem_q, rem_d;
  logic [TBITS-1:0] age_q [CHANNELS];
  logic [TBITS-1:0] age_d [CHANNELS];

  logic [LBITS-1:0]    lvl [CHANNELS];
  logic [CHANNELS-1:0] elig;
  logic                found;
  logic [CBITS-1:0]    pick;
  logic [LBITS-1:0]    pick_lvl;
  logic                grant;
  logic                in_burst;
  logic                xfer;

  // Effective level (a full FIFO reports level 0 with valid set) and eligibility per channel
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      lvl[c] = {1'b0, level_i[c*ABITS +: ABITS]};
      if (level_i[c*ABITS +: ABITS] == '0 && valid_i[c]) begin
        lvl[c] = LBITS'(1 << ABITS);
      end
      elig[c] = valid_i[c] && (lvl[c] >= LBITS'(THRESH) || age_q[c] == TBITS'(TIMEOUT));
    end
  end

  // Channel selection: strict lowest index, or first eligible after the RR pointer
  always_comb begin
    found = 1'b0;
    pick  = '0;
`ifdef FIFO_SCHED_STRICT_EN
    for (int i = 0; i < CHANNELS; i++) begin
      if (!found && elig[i]) begin
        found = 1'b1;
        pick  = CBITS'(i);
      end
    end
`else
    for (int k = 1; k <= CHANNELS; k++) begin
      if (!found && elig[(int'(rr_q) + k) % CHANNELS]) begin
        found = 1'b1;
        pick  = CBITS'((int'(rr_q) + k) % CHANNELS);
      end
    end
`endif
    pick_lvl = lvl[pick];
  end

  assign in_burst = (state_q == S_BURST);
  assign grant    = (state_q == S_IDLE) && enable_i && found;

  // Zero-latency pass-through of the granted channel while a burst is open
  always_comb begin
    ready_o = '0;
    valid_o = 1'b0;
    data_o  = '0;
    if (in_burst) begin
      ready_o[chan_q] = ready_i;
      valid_o         = valid_i[chan_q];
      data_o          = data_i[chan_q*WIDTH +: WIDTH];
    end
  end

  assign xfer   = valid_o && ready_i;
  assign last_o = valid_o && (rem_q == RBITS'(1));
  assign busy_o = in_burst;
  assign chan_o = chan_q;

  // FSM and burst word counter; remaining is a snapshot of queued words so it cannot underflow
  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    rr_d    = rr_q;
    rem_d   = rem_q;
    if (state_q == S_IDLE) begin
      if (grant) begin
        state_d = S_BURST;
        chan_d  = pick;
        rr_d    = pick;
        rem_d   = (pick_lvl > LBITS'(BURST)) ? RBITS'(BURST) : RBITS'(pick_lvl);
      end
    end else if (xfer) begin
      rem_d = rem_q - RBITS'(1);
      if (rem_q == RBITS'(1)) begin
        state_d = S_IDLE;
      end
    end
  end

  // Age timers: a channel being served (granted now or bursting) or empty does not age
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      age_d[c] = age_q[c];
      if (!valid_i[c] || (grant && pick == CBITS'(c)) || (in_burst && chan_q == CBITS'(c))) begin
        age_d[c] = '0;
      end else if (age_q[c] != TBITS'(TIMEOUT)) begin
        age_d[c] = age_q[c] + TBITS'(1);
      end
    end
  end

  // State registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      chan_q  <= '0;
      rr_q    <= CBITS'(CHANNELS - 1);
      rem_q   <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        age_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      rr_q    <= rr_d;
      rem_q   <= rem_d;
      for (int c = 0; c < CHANNELS; c++) begin
        age_q[c] <= age_d[c];
      end
    end
  end

endmodule

// File: tb/tb_fifo_burst_scheduler.sv
// tb/tb_fifo_burst_scheduler.sv - directed self-checking bench for fifo_burst_scheduler
module tb_fifo_burst_scheduler;

  logic        clock;
  logic        reset_n;
  logic        enable_i;
  logic [15:0] level_i;
  logic [3:0]  valid_i;
  logic [3:0]  ready_o;
  logic [31:0] data_i;
  logic        valid_o;
  logic        ready_i;
  logic        last_o;
  logic [7:0]  data_o;
  logic [1:0]  chan_o;
  logic        busy_o;

  int ncmp = 0;
  int nerr = 0;

  logic [7:0] fq [4][$];
  logic [7:0] log_d [$];
  logic       log_l [$];
  logic [1:0] log_c [$];

  fifo_burst_scheduler dut (
    .clock(clock), .reset_n(reset_n), .enable_i(enable_i), .level_i(level_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i), .valid_o(valid_o),
    .ready_i(ready_i), .last_o(last_o), .data_o(data_o), .chan_o(chan_o), .busy_o(busy_o)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [7:0] word(input int c, input int i);
    return 8'(c * 32 + i);
  endfunction

  task automatic drive_inputs();
    for (int c = 0; c < 4; c++) begin
      level_i[c*4 +: 4] = 4'(fq[c].size());
      valid_i[c]        = (fq[c].size() > 0);
      data_i[c*8 +: 8]  = (fq[c].size() > 0) ? fq[c][0] : 8'h00;
    end
  endtask

  task automatic push(input int c, input int n);
    for (int i = 0; i < n; i++) fq[c].push_back(word(c, i));
    drive_inputs();
  endtask

  task automatic clear_log();
    log_d.delete();
    log_l.delete();
    log_c.delete();
  endtask

  // One clock: record any transfer, take the edge, pop the sources that handed a word over
  task automatic cycle();
    logic [3:0] pop;
    #1;
    pop = ready_o & valid_i;
    if (valid_o && ready_i) begin
      log_d.push_back(data_o);
      log_l.push_back(last_o);
      log_c.push_back(chan_o);
    end
    @(posedge clock);
    #1;
    for (int c = 0; c < 4; c++) if (pop[c]) void'(fq[c].pop_front());
    drive_inputs();
    #1;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    enable_i = 1'b1;
    ready_i  = 1'b0;
    for (int c = 0; c < 4; c++) fq[c].delete();
    drive_inputs();
    repeat (2) @(posedge clock);
    #2;
    reset_n = 1'b1;
    clear_log();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    ncmp++; if (valid_o !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    ncmp++; if (busy_o !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    ncmp++; if (ready_o !== 4'h0) begin nerr++; $display("FAIL reset_ready: got %h want 0", ready_o); end
    ncmp++; if ({last_o, chan_o, data_o} !== 11'h0) begin nerr++; $display("FAIL reset_misc: got %h want 0", {last_o, chan_o, data_o}); end
  endtask

  task automatic test_single_burst();
    int n;
    do_reset();
    ready_i = 1'b1;
    push(0, 4);
    cycle();
    ncmp++; if (busy_o !== 1'b1 || valid_o !== 1'b1) begin nerr++; $display("FAIL single_grant: got busy=%b valid=%b want 1 1", busy_o, valid_o); end
    ncmp++; if (data_o !== word(0, 0)) begin nerr++; $display("FAIL single_first_data: got %h want %h", data_o, word(0, 0)); end
    n = 0;
    while (log_d.size() < 4 && n < 12) begin cycle(); n++; end
    ncmp++; if (log_d.size() !== 4) begin nerr++; $display("FAIL single_count: got %0d want 4", log_d.size()); end
    for (int i = 0; i < log_d.size(); i++) begin
      ncmp++;
      if (log_d[i] !== word(0, i) || log_l[i] !== (i == 3) || log_c[i] !== 2'd0) begin
        nerr++; $display("FAIL single_word%0d: got d=%h l=%b c=%0d want d=%h l=%b c=0", i, log_d[i], log_l[i], log_c[i], word(0, i), (i == 3));
      end
    end
    ncmp++; if (busy_o !== 1'b0) begin nerr++; $display("FAIL single_busy_end: got %b want 0", busy_o); end
  endtask

  task automatic test_round_robin();
    int n;
    int seen [4];
    logic [1:0] ec;
    do_reset();
    ready_i = 1'b1;
    push(1, 16);
    push(2, 16);
    for (int c = 0; c < 4; c++) seen[c] = 0;
    n = 0;
    while (log_d.size() < 32 && n < 60) begin cycle(); n++; end
    ncmp++; if (n !== 36) begin nerr++; $display("FAIL rr_cycles: got %0d want 36", n); end
    ncmp++; if (log_d.size() !== 32) begin nerr++; $display("FAIL rr_count: got %0d want 32", log_d.size()); end
    for (int k = 0; k < log_d.size(); k++) begin
`ifdef FIFO_SCHED_STRICT_EN
      ec = (k < 16) ? 2'd1 : 2'd2;
`else
      ec = ((k / 8) % 2 == 0) ? 2'd1 : 2'd2;
`endif
      ncmp++;
      if (log_c[k] !== ec || log_d[k] !== word(ec, seen[ec]) || log_l[k] !== (k % 8 == 7)) begin
        nerr++; $display("FAIL rr_word%0d: got c=%0d d=%h l=%b want c=%0d d=%h l=%b", k, log_c[k], log_d[k], log_l[k], ec, word(ec, seen[ec]), (k % 8 == 7));
      end
      seen[ec]++;
    end
  endtask

  task automatic test_timeout();
    int first_busy;
    do_reset();
    ready_i = 1'b1;
    push(3, 1);
    first_busy = -1;
    for (int k = 1; k <= 70; k++) begin
      cycle();
      if (busy_o && first_busy < 0) first_busy = k;
    end
    ncmp++; if (first_busy !== 65) begin nerr++; $display("FAIL timeout_grant_cycle: got %0d want 65", first_busy); end
    ncmp++; if (log_d.size() !== 1) begin nerr++; $display("FAIL timeout_count: got %0d want 1", log_d.size()); end
    if (log_d.size() > 0) begin
      ncmp++;
      if (log_d[0] !== word(3, 0) || log_l[0] !== 1'b1 || log_c[0] !== 2'd3) begin
        nerr++; $display("FAIL timeout_word: got d=%h l=%b c=%0d want d=%h l=1 c=3", log_d[0], log_l[0], log_c[0], word(3, 0));
      end
    end
  endtask

  task automatic test_full_fifo();
    int n;
    do_reset();
    ready_i = 1'b1;
    push(0, 16);
    ncmp++; if (level_i[3:0] !== 4'h0 || valid_i[0] !== 1'b1) begin nerr++; $display("FAIL full_setup: got lvl=%h v=%b want 0 1", level_i[3:0], valid_i[0]); end
    n = 0;
    while (log_d.size() < 16 && n < 40) begin cycle(); n++; end
    ncmp++; if (n !== 18) begin nerr++; $display("FAIL full_cycles: got %0d want 18", n); end
    for (int k = 0; k < log_d.size(); k++) begin
      ncmp++;
      if (log_d[k] !== word(0, k) || log_l[k] !== (k % 8 == 7)) begin
        nerr++; $display("FAIL full_word%0d: got d=%h l=%b want d=%h l=%b", k, log_d[k], log_l[k], word(0, k), (k % 8 == 7));
      end
    end
  endtask

  task automatic test_ready_toggle();
    do_reset();
    push(1, 6);
    for (int k = 0; k < 30; k++) begin
      ready_i = k[0];
      cycle();
    end
    ncmp++; if (log_d.size() !== 6) begin nerr++; $display("FAIL toggle_count: got %0d want 6", log_d.size()); end
    for (int k = 0; k < log_d.size(); k++) begin
      ncmp++;
      if (log_d[k] !== word(1, k) || log_l[k] !== (k == 5) || log_c[k] !== 2'd1) begin
        nerr++; $display("FAIL toggle_word%0d: got d=%h l=%b c=%0d want d=%h l=%b c=1", k, log_d[k], log_l[k], log_c[k], word(1, k), (k == 5));
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int n;
    do_reset();
    ready_i = 1'b1;
    push(2, 8);
    repeat (3) cycle();
    ncmp++; if (valid_o !== 1'b1 || data_o !== word(2, 2)) begin nerr++; $display("FAIL midrst_pre: got v=%b d=%h want 1 %h", valid_o, data_o, word(2, 2)); end
    #2;
    reset_n = 1'b0;
    #1;
    ncmp++; if ({valid_o, busy_o, last_o} !== 3'b000) begin nerr++; $display("FAIL midrst_flags: got %b want 000", {valid_o, busy_o, last_o}); end
    ncmp++; if ({ready_o, chan_o, data_o} !== 14'h0) begin nerr++; $display("FAIL midrst_data: got %h want 0", {ready_o, chan_o, data_o}); end
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    clear_log();
    ncmp++; if (fq[2].size() !== 6) begin nerr++; $display("FAIL midrst_remaining: got %0d want 6", fq[2].size()); end
    n = 0;
    while (log_d.size() < 6 && n < 20) begin cycle(); n++; end
    ncmp++; if (log_d.size() !== 6) begin nerr++; $display("FAIL midrst_count: got %0d want 6", log_d.size()); end
    for (int k = 0; k < log_d.size(); k++) begin
      ncmp++;
      if (log_d[k] !== word(2, k + 2) || log_l[k] !== (k == 5) || log_c[k] !== 2'd2) begin
        nerr++; $display("FAIL midrst_word%0d: got d=%h l=%b c=%0d want d=%h l=%b c=2", k, log_d[k], log_l[k], log_c[k], word(2, k + 2), (k == 5));
      end
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    enable_i = 1'b0;
    ready_i  = 1'b0;
    level_i  = '0;
    valid_i  = '0;
    data_i   = '0;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_timeout();
    test_full_fifo();
    test_ready_toggle();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
